mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM/WB pipeline stage with a valid/ready handshake, flush, and write-back data selection. It sits between the data-memory stage and the register file. It replaces the fixed, always-advancing MEM/WB latch: the stage holds under back-pressure, converts flushed instructions into bubbles, and resolves the final write-back value and write enable itself. A saturating stall counter supports performance analysis.

## Interface
Parameters:
- DATA_W, 32, width of data, ALU result, PC and write-back value
- REG_AW, 5, register-address width
- LINK_OFFSET, 8, constant added to PC for link (jump-and-link) write-back
- STALL_CNT_W, 16, width of the stall counter

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- flush  in  1  kill stage contents (bubble)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_reg_write  in  1  instruction writes a register
- in_wb_sel  in  2  0=ALU, 1=MEM, 2=LINK, 3=MOV
- in_mov_cond  in  1  condition for MOV (write only if 1)
- in_mem_data  in  DATA_W  memory read data
- in_alu_result  in  DATA_W  ALU result
- in_pc  in  DATA_W  instruction PC
- in_wr_reg  in  REG_AW  destination register
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  register file / downstream accepts
- out_reg_write  out  1  qualified write enable
- out_wr_reg  out  REG_AW  destination register
- out_wr_data  out  DATA_W  selected write-back value
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- A beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
- The stage captures all in_* fields on the input transfer. Captured data holds unchanged while out_valid && !out_ready.
- out_wr_data is a combinational mux of the registered fields:
  - ALU → alu_result
  - MEM → mem_data
  - LINK → pc + LINK_OFFSET, modulo 2^DATA_W
  - MOV → alu_result
- out_reg_write = out_valid && reg_write && (wr_reg != 0) && (sel != MOV || mov_cond).
- Register 0 is never written.
- flush=1: next cycle out_valid=0 and any skid entry is cleared. A beat accepted in the same cycle is discarded. Flush beats a simultaneous input transfer.
- stall_cnt increments each cycle with out_valid && !out_ready. It saturates at all-ones and never wraps.

## Timing
- Latency is 1 cycle from input transfer to out_valid. Throughput is 1 beat per cycle when out_ready=1.
- Reset: out_valid=0, skid empty, all data registers 0, stall_cnt=0. Therefore out_reg_write=0 and out_wr_data=0.
- in_ready=0 during reset.
- Reset mid-stall discards the held instruction.
- Simultaneous output transfer and input transfer: the new beat replaces the old one in the same edge, with no bubble.
- Output fields must be stable while out_valid && !out_ready.

## Configuration
- Macro MEM_WB_STAGE_SKID_EN.
- Defined:
  - One-entry skid buffer.
  - in_ready is a register output, equal to !skid_valid, with no combinational path from out_ready.
  - A beat arriving while the main stage is stalled goes to skid.
  - On the next output transfer, skid moves to the main stage.
  - Order is preserved.
- Undefined:
  - No skid.
  - in_ready = !out_valid || out_ready, combinational.

## Structure
- Shared package holds:
  - the wb_sel encoding constants WB_ALU, WB_MEM, WB_LINK, WB_MOV
  - a packed struct of the stage payload (reg_write, wb_sel, mov_cond, mem_data, alu_result, pc, wr_reg)
- One sub-module, wb_select: the combinational write-back mux and write-enable qualification. It is reused by the forwarding unit.

## Test plan
- After reset, drive in_valid=1, sel=ALU, alu=0x1234, wr_reg=3, with out_ready=1.
  - Next cycle: out_valid=1, out_wr_data=0x1234, out_reg_write=1.
- sel=LINK, pc=0x0040_0010.
  - out_wr_data=0x0040_0018.
  - Also check pc=0xFFFF_FFFC → 0x0000_0004.
- sel=MOV with mov_cond=0 → out_reg_write=0. Any sel with wr_reg=0 → out_reg_write=0.
- Hold out_ready=0 for 5 cycles with a valid beat.
  - Outputs stay stable and stall_cnt=5.
  - With STALL_CNT_W=4, 20 stall cycles → stall_cnt=15.
- Assert flush together with an input transfer → next cycle out_valid=0. The dropped beat never appears.
- With MEM_WB_STAGE_SKID_EN, stall the output and push 2 beats (A, B).
  - in_ready drops after B.
  - Release out_ready → A then B on consecutive cycles.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: write-back select encoding and the
// stage payload layout at the default widths (DATA_W=32, REG_AW=5).
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_MOV  = 2'd3;

  localparam int PAYLOAD_DATA_W = 32;
  localparam int PAYLOAD_REG_AW = 5;

  typedef struct packed {
    logic                      reg_write;
    logic [1:0]                wb_sel;
    logic                      mov_cond;
    logic [PAYLOAD_DATA_W-1:0] mem_data;
    logic [PAYLOAD_DATA_W-1:0] alu_result;
    logic [PAYLOAD_DATA_W-1:0] pc;
    logic [PAYLOAD_REG_AW-1:0] wr_reg;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_stage_wb_select.sv
// Combinational write-back value mux and write-enable qualification; shared
// with the forwarding unit so both agree on the final write-back value.
module wb_select
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 8
) (
  input  logic              valid,
  input  logic              reg_write,
  input  logic [1:0]        wb_sel,
  input  logic              mov_cond,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc,
  input  logic [REG_AW-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  always_comb begin
    wr_data = alu_result;
    case (wb_sel)
      WB_MEM:  wr_data = mem_data;
      WB_LINK: wr_data = pc + DATA_W'(LINK_OFFSET);
      default: wr_data = alu_result;
    endcase
  end

  // Register 0 is hardwired; a MOV with a false condition is a no-op.
  assign wr_en = valid && reg_write && (wr_reg != '0) &&
                 ((wb_sel != WB_MOV) || mov_cond);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with valid/ready handshake, flush and stall counter.
// Define MEM_WB_STAGE_SKID_EN for a one-entry skid buffer with registered in_ready.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_reg_write,
  input  logic [1:0]             in_wb_sel,
  input  logic                   in_mov_cond,
  input  logic [DATA_W-1:0]      in_mem_data,
  input  logic [DATA_W-1:0]      in_alu_result,
  input  logic [DATA_W-1:0]      in_pc,
  input  logic [REG_AW-1:0]      in_wr_reg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_reg_write,
  output logic [REG_AW-1:0]      out_wr_reg,
  output logic [DATA_W-1:0]      out_wr_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Same field order as mem_wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic              mov_cond;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] wr_reg;
  } payload_t;

  // Handshake: a beat moves when valid && ready on the same rising edge; valid
  // never waits on ready, and a held beat stays bit-stable until it moves.
  payload_t in_beat;
  payload_t main_q;
  logic     main_valid;
  logic     in_fire;
  logic     out_fire;

  assign in_beat = '{reg_write:  in_reg_write,
                     wb_sel:     in_wb_sel,
                     mov_cond:   in_mov_cond,
                     mem_data:   in_mem_data,
                     alu_result: in_alu_result,
                     pc:         in_pc,
                     wr_reg:     in_wr_reg};

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

`ifdef MEM_WB_STAGE_SKID_EN
  payload_t skid_q;
  logic     skid_valid;

  assign in_ready = !skid_valid && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      main_valid <= 1'b0;
      main_q     <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_fire || !main_valid) begin
      // Main slot frees up: the older skid beat has priority to keep order.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q     <= in_beat;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= in_beat;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = (!main_valid || out_ready) && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      main_valid <= 1'b0;
      main_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (in_fire) begin
      main_q     <= in_beat;
      main_valid <= 1'b1;
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign out_wr_reg = main_q.wr_reg;

  wb_select #(
    .DATA_W      (DATA_W),
    .REG_AW      (REG_AW),
    .LINK_OFFSET (LINK_OFFSET)
  ) u_wb_select (
    .valid      (main_valid),
    .reg_write  (main_q.reg_write),
    .wb_sel     (main_q.wb_sel),
    .mov_cond   (main_q.mov_cond),
    .mem_data   (main_q.mem_data),
    .alu_result (main_q.alu_result),
    .pc         (main_q.pc),
    .wr_reg     (main_q.wr_reg),
    .wr_data    (out_wr_data),
    .wr_en      (out_reg_write)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a default instance plus a 4-bit stall
// counter instance sharing the same stimulus.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic        in_mov_cond;
  logic [31:0] in_mem_data;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [4:0]  in_wr_reg;
  logic        out_valid;
  logic        out_ready;
  logic        out_reg_write;
  logic [4:0]  out_wr_reg;
  logic [31:0] out_wr_data;
  logic [15:0] stall_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic        out_reg_write4;
  logic [4:0]  out_wr_reg4;
  logic [31:0] out_wr_data4;
  logic [3:0]  stall_cnt4;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mem_wb_stage dut (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_mov_cond(in_mov_cond), .in_mem_data(in_mem_data),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_wr_reg(in_wr_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg_write(out_reg_write),
    .out_wr_reg(out_wr_reg), .out_wr_data(out_wr_data), .stall_cnt(stall_cnt)
  );

  mem_wb_stage #(.STALL_CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_mov_cond(in_mov_cond), .in_mem_data(in_mem_data),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_wr_reg(in_wr_reg),
    .out_valid(out_valid4), .out_ready(out_ready), .out_reg_write(out_reg_write4),
    .out_wr_reg(out_wr_reg4), .out_wr_data(out_wr_data4), .stall_cnt(stall_cnt4)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_beat(input logic [1:0] sel, input logic cond, input logic wr,
                            input logic [31:0] mem, input logic [31:0] alu,
                            input logic [31:0] pc, input logic [4:0] rg);
    in_valid      = 1'b1;
    in_reg_write  = wr;
    in_wb_sel     = sel;
    in_mov_cond   = cond;
    in_mem_data   = mem;
    in_alu_result = alu;
    in_pc         = pc;
    in_wr_reg     = rg;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_wb_sel     = 2'd0;
    in_mov_cond   = 1'b0;
    in_mem_data   = '0;
    in_alu_result = '0;
    in_pc         = '0;
    in_wr_reg     = '0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_wr_data); end
    checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", out_reg_write); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    Rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_alu_mem();
    out_ready = 1'b1;
    drive_beat(2'd0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_1234, 32'h0, 5'd3);
    tick();
    idle_inputs();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b want 1", out_valid); end
    checks++; if (out_wr_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got %h want 00001234", out_wr_data); end
    checks++; if (out_reg_write !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", out_reg_write); end
    checks++; if (out_wr_reg !== 5'd3) begin errors++; $display("FAIL alu_reg got %0d want 3", out_wr_reg); end
    drive_beat(2'd1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0, 5'd7);
    tick();
    idle_inputs();
    checks++; if (out_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mem_data got %h want deadbeef", out_wr_data); end
    checks++; if (out_wr_reg !== 5'd7) begin errors++; $display("FAIL mem_reg got %0d want 7", out_wr_reg); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back_link();
    out_ready = 1'b1;
    drive_beat(2'd2, 1'b0, 1'b1, 32'h0, 32'h2222, 32'h0040_0010, 5'd31);
    tick();
    checks++; if (out_wr_data !== 32'h0040_0018) begin errors++; $display("FAIL link_data got %h want 00400018", out_wr_data); end
    drive_beat(2'd2, 1'b0, 1'b1, 32'h0, 32'h2222, 32'hFFFF_FFFC, 5'd31);
    tick();
    idle_inputs();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    checks++; if (out_wr_data !== 32'h0000_0004) begin errors++; $display("FAIL link_wrap got %h want 00000004", out_wr_data); end
    tick();
  endtask

  task automatic test_write_enable();
    out_ready = 1'b1;
    drive_beat(2'd3, 1'b0, 1'b1, 32'h0, 32'h0000_0055, 32'h0, 5'd4);
    tick();
    checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL mov_false_we got %b want 0", out_reg_write); end
    checks++; if (out_wr_data !== 32'h0000_0055) begin errors++; $display("FAIL mov_data got %h want 00000055", out_wr_data); end
    drive_beat(2'd3, 1'b1, 1'b1, 32'h0, 32'h0000_0066, 32'h0, 5'd4);
    tick();
    checks++; if (out_reg_write !== 1'b1) begin errors++; $display("FAIL mov_true_we got %b want 1", out_reg_write); end
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0077, 32'h0, 5'd0);
    tick();
    checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL r0_alu_we got %b want 0", out_reg_write); end
    drive_beat(2'd1, 1'b0, 1'b1, 32'h0000_0088, 32'h0, 32'h0, 5'd0);
    tick();
    checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL r0_mem_we got %b want 0", out_reg_write); end
    drive_beat(2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0099, 32'h0, 5'd6);
    tick();
    idle_inputs();
    checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL nowrite_we got %b want 0", out_reg_write); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_ABCD, 32'h0, 5'd9);
    tick();
    idle_inputs();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_wr_data !== 32'h0000_ABCD || out_wr_reg !== 5'd9 || out_reg_write !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got v=%b d=%h r=%0d we=%b want v=1 d=0000abcd r=9 we=1",
                 i, out_valid, out_wr_data, out_wr_reg, out_reg_write);
      end
    end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
`ifndef MEM_WB_STAGE_SKID_EN
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
`endif
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", out_valid); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt_hold got %0d want 5", stall_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0042, 32'h0, 5'd2);
    tick();
    idle_inputs();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d want 15", stall_cnt4); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL stall_20 got %0d want 20", stall_cnt); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0777, 32'h0, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_valid got %b want 0", out_valid); end
    checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL flush_drop_we got %b want 0", out_reg_write); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_never_appears got %b want 0", out_valid); end
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0888, 32'h0, 5'd8);
    tick();
    out_ready = 1'b0;
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0999, 32'h0, 5'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_cleared got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1;
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_0123, 32'h0, 5'd10);
    tick();
    idle_inputs();
    out_ready = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got %b want 0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (out_wr_data !== 32'h0) begin errors++; $display("FAIL rst_stall_data got %h want 0", out_wr_data); end
  endtask

`ifdef MEM_WB_STAGE_SKID_EN
  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_000A, 32'h0, 5'd1);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_a got %b want 1", in_ready); end
    drive_beat(2'd0, 1'b0, 1'b1, 32'h0, 32'h0000_000B, 32'h0, 5'd2);
    tick();
    idle_inputs();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_b got %b want 0", in_ready); end
    checks++; if (out_wr_data !== 32'h0000_000A) begin errors++; $display("FAIL skid_hold_a got %h want 0000000a", out_wr_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wr_data !== 32'h0000_000A) begin errors++; $display("FAIL skid_out_a got v=%b d=%h want v=1 d=0000000a", out_valid, out_wr_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_wr_data !== 32'h0000_000B) begin errors++; $display("FAIL skid_out_b got v=%b d=%h want v=1 d=0000000b", out_valid, out_wr_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain got %b want 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_mem();
    test_back_to_back_link();
    test_write_enable();
    test_stall();
    test_saturate();
    test_flush();
    test_reset_mid_stall();
`ifdef MEM_WB_STAGE_SKID_EN
    test_skid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
